reaction_responder: RTL and testbench



---
 rtl/reaction_responder.sv | 154 +++++++++++++++
 tb/tb_reaction_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reaction_responder.sv
// Automated player for the reaction-timer game: waits delay_ms after the go-light, then holds btn.
// Optional build macro RESP_JITTER_EN adds an 8-bit LFSR jitter (0..15 ms) to the latched delay.
module reaction_responder #(
  parameter int CLK_PER_MS = 100000,
  parameter int DELAY_W    = 10,
  parameter int PRESS_MS   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               stim,
  input  logic [DELAY_W-1:0] delay_ms,
  input  logic               cheat,
  output logic               btn,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int TW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
`ifdef RESP_JITTER_EN
  localparam int RW = DELAY_W + 1;
`else
  localparam int RW = DELAY_W;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    PRESS   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic            stim_q_r;
  logic [TW-1:0]   tick_r;
  logic [RW-1:0]   rem_r;
  logic            done_r, aborted_r;
  logic            btn_s, busy_s;
  logic            rise_s, wrap_s, last_s;
  logic [RW-1:0]   load_s;

  assign rise_s = stim & ~stim_q_r;
  assign wrap_s = (tick_r == TW'(CLK_PER_MS - 1));
  assign last_s = wrap_s && (rem_r == RW'(1));

`ifdef RESP_JITTER_EN
  logic [7:0] lfsr_r;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  // One extra bit keeps delay_ms + jitter from wrapping
  assign load_s = RW'(delay_ms) + RW'(lfsr_r[3:0]);
`else
  assign load_s = delay_ms;
`endif

  // State register, ms counters and registered event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      stim_q_r  <= 1'b0;
      tick_r    <= {TW{1'b0}};
      rem_r     <= {RW{1'b0}};
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      stim_q_r  <= stim;
      done_r    <= (state_r == PRESS) && (state_s == RELEASE);
      aborted_r <= (state_r == DELAY) && (state_s == ARMED);
      if ((state_s == PRESS) && (state_r != PRESS)) begin
        tick_r <= {TW{1'b0}};
        rem_r  <= RW'(PRESS_MS);
      end else if ((state_s == DELAY) && (state_r != DELAY)) begin
        tick_r <= {TW{1'b0}};
        rem_r  <= load_s;
      end else if ((state_r == DELAY) || (state_r == PRESS)) begin
        if (wrap_s) begin
          tick_r <= {TW{1'b0}};
          rem_r  <= rem_r - RW'(1);
        end else begin
          tick_r <= tick_r + TW'(1);
        end
      end else begin
        tick_r <= {TW{1'b0}};
      end
    end
  end

  // Next-state logic; en low overrides every transition
  always_comb begin
    state_s = state_r;
    if (!en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = ARMED;
        ARMED: begin
          if (cheat) begin
            state_s = PRESS;
          end else if (rise_s) begin
            state_s = (load_s == {RW{1'b0}}) ? PRESS : DELAY;
          end else begin
            state_s = ARMED;
          end
        end
        DELAY: begin
          if (!stim) begin
            state_s = ARMED;
          end else if (last_s) begin
            state_s = PRESS;
          end else begin
            state_s = DELAY;
          end
        end
        PRESS:   state_s = last_s ? RELEASE : PRESS;
        RELEASE: state_s = stim ? RELEASE : ARMED;
        default: state_s = IDLE;
      endcase
    end
  end

  // Moore output decode of the state register
  always_comb begin
    btn_s  = 1'b0;
    busy_s = 1'b0;
    case (state_r)
      DELAY:   busy_s = 1'b1;
      PRESS: begin
        btn_s  = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        btn_s  = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  assign btn     = btn_s;
  assign busy    = busy_s;
  assign done    = done_r;
  assign aborted = aborted_r;

endmodule

// File: tb/tb_reaction_responder.sv
// Directed self-checking bench for reaction_responder (CLK_PER_MS=10, PRESS_MS=2).
// Define RESP_JITTER_EN for both files to exercise the jitter trials.
module tb_reaction_responder;

  logic       clk = 1'b0;
  logic       rst_n, en, stim, cheat;
  logic [9:0] delay_ms;
  logic       btn, busy, done, aborted;

  int n_checks = 0;
  int n_errors = 0;

  int first_btn, last_btn, btn_cnt, done_cnt, done_at, abort_cnt, abort_at;
  int busy_first, busy_last, both_cnt;

  reaction_responder #(.CLK_PER_MS(10), .DELAY_W(10), .PRESS_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stim(stim), .delay_ms(delay_ms),
    .cheat(cheat), .btn(btn), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 none, 1 drop stim at step 'at', 2 en low at 'at', 3 reset low for steps at..at+2
  task automatic run_window(input int n, input int kind, input int at);
    first_btn = 0; last_btn = 0; btn_cnt = 0; done_cnt = 0; done_at = 0;
    abort_cnt = 0; abort_at = 0; busy_first = 0; busy_last = 0; both_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (btn) begin
        if (first_btn == 0) first_btn = k;
        last_btn = k;
        btn_cnt++;
      end
      if (busy) begin
        if (busy_first == 0) busy_first = k;
        busy_last = k;
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (aborted) begin
        abort_cnt++;
        if (abort_at == 0) abort_at = k;
      end
      if (done && aborted) both_cnt++;
      if (k == 1) delay_ms = 10'd7;
      if (kind == 1 && k == at) stim = 1'b0;
      if (kind == 2 && k == at) en = 1'b0;
      if (kind == 3 && k == at) rst_n = 1'b0;
      if (kind == 3 && k == at + 3) rst_n = 1'b1;
    end
  endtask

  task automatic rearm();
    stim  = 1'b0;
    cheat = 1'b0;
    en    = 1'b1;
    step();
    step();
  endtask

`ifdef RESP_JITTER_EN
  logic [7:0] model_lfsr;
  always @(posedge clk) begin
    if (!rst_n) model_lfsr <= 8'hA5;
    else        model_lfsr <= {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
  end
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; stim = 1'b0; cheat = 1'b0; delay_ms = 10'd0;
    step();
    step();
    check_eq("reset_btn", btn, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_aborted", aborted, 0);

    rst_n = 1'b1;
    rearm();

    // delay 5 ms; delay_ms rewritten after the rise must be ignored
    delay_ms = 10'd5; stim = 1'b1;
    run_window(100, 0, 0);
    check_eq("d5_first_btn", first_btn, 51);
    check_eq("d5_last_btn", last_btn, 70);
    check_eq("d5_btn_cnt", btn_cnt, 20);
    check_eq("d5_busy_first", busy_first, 1);
    check_eq("d5_busy_last", busy_last, 70);
    check_eq("d5_done_cnt", done_cnt, 1);
    check_eq("d5_done_at", done_at, 71);
    check_eq("d5_abort_cnt", abort_cnt, 0);
    check_eq("d5_both", both_cnt, 0);
    rearm();

    delay_ms = 10'd0; stim = 1'b1;
    run_window(60, 0, 0);
    check_eq("d0_first_btn", first_btn, 1);
    check_eq("d0_btn_cnt", btn_cnt, 20);
    check_eq("d0_done_cnt", done_cnt, 1);
    check_eq("d0_done_at", done_at, 21);
    rearm();

    delay_ms = 10'd5; stim = 1'b1; cheat = 1'b1;
    run_window(60, 0, 0);
    check_eq("cheat_first_btn", first_btn, 1);
    check_eq("cheat_btn_cnt", btn_cnt, 20);
    check_eq("cheat_busy_last", busy_last, 20);
    check_eq("cheat_done_cnt", done_cnt, 1);
    rearm();

    delay_ms = 10'd8; stim = 1'b1;
    run_window(100, 1, 30);
    check_eq("abort_cnt", abort_cnt, 1);
    check_eq("abort_at", abort_at, 31);
    check_eq("abort_btn_cnt", btn_cnt, 0);
    check_eq("abort_done_cnt", done_cnt, 0);
    check_eq("abort_busy_last", busy_last, 30);
    check_eq("abort_both", both_cnt, 0);
    // Block must be back in ARMED: a zero-delay rise presses on the next cycle
    delay_ms = 10'd0; stim = 1'b1;
    run_window(30, 0, 0);
    check_eq("post_abort_first_btn", first_btn, 1);
    rearm();

    delay_ms = 10'd0; stim = 1'b1;
    run_window(40, 2, 5);
    check_eq("en_off_btn_cnt", btn_cnt, 5);
    check_eq("en_off_last_btn", last_btn, 5);
    check_eq("en_off_done_cnt", done_cnt, 0);
    check_eq("en_off_busy_last", busy_last, 5);
    rearm();

    // stim stays high across the reset, so ARMED re-entry must see no rise
    delay_ms = 10'd0; stim = 1'b1;
    run_window(40, 3, 5);
    check_eq("rst_btn_cnt", btn_cnt, 5);
    check_eq("rst_last_btn", last_btn, 5);
    check_eq("rst_done_cnt", done_cnt, 0);
    check_eq("rst_busy_last", busy_last, 5);
    rearm();

`ifdef RESP_JITTER_EN
    begin
      bit [15:0] seen;
      int        distinct;
      int        j;
      seen = 16'd0;
      rst_n = 1'b0; en = 1'b0; stim = 1'b0;
      step();
      rst_n = 1'b1; en = 1'b1;
      step();
      for (int t = 0; t < 8; t++) begin
        delay_ms = 10'd3;
        j = int'(model_lfsr[3:0]);
        seen[j] = 1'b1;
        stim = 1'b1;
        run_window(240, 0, 0);
        check_eq("jit_first_btn", first_btn, (3 + j) * 10 + 1);
        stim = 1'b0;
        for (int g = 0; g < t + 2; g++) step();
      end
      distinct = 0;
      for (int b = 0; b < 16; b++) if (seen[b]) distinct++;
      check_eq("jit_distinct_ge3", int'(distinct >= 3), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
